audio_sample_buffer: RTL and testbench

AUDIO_SAMPLE_BUFFER -- requirements
Module: audio_sample_buffer

---
 rtl/audio_sample_buffer.sv | 195 +++++++++++++++++++
 tb/tb_audio_sample_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module   : audio_sample_buffer
// Purpose  : Stereo 24-bit frame FIFO between the audio front-end and the DSP
//            engine, with a fill/run/underrun controller and a hold register.
//            The hold register supplies the last delivered frame whenever
//            the FIFO runs dry.
// Ports    : clk_sys, rst           - clock, asynchronous active-high reset
//            in_left/in_right       - signed frame to push (in_valid strobe)
//            out_req                - one-cycle frame request
//            out_left/out_right     - frame answered one cycle after out_req
//            out_valid              - strobe qualifying out_left/out_right
//            level                  - FIFO occupancy in frames
//            state                  - FILL=0, RUN=1, UNDERRUN=2
//            overflow_sticky        - a push was dropped on a full FIFO
//            underrun_sticky        - a request found the FIFO empty in RUN
//            clear_flags            - clears both sticky flags
// Options  : AUDIO_SAMPLE_BUFFER_DECAY_EN - when defined, each hold channel
//            is arithmetic-shifted right by one after every hold output, so
//            an underrun fades towards silence instead of repeating.
// Revision : 1.0 - initial release
// ============================================================================
module audio_sample_buffer #(
  parameter int DEPTH      = 16,
  parameter int FILL_LEVEL = 8
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic [23:0]            in_left,
  input  logic [23:0]            in_right,
  input  logic                   in_valid,
  input  logic                   out_req,
  input  logic                   clear_flags,
  output logic [23:0]            out_left,
  output logic [23:0]            out_right,
  output logic                   out_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic [1:0]             state,
  output logic                   overflow_sticky,
  output logic                   underrun_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] C_FILL  = LW'(FILL_LEVEL);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    RUN      = 2'd1,
    UNDERRUN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [23:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [23:0]   out_l_q, out_l_d, out_r_q, out_r_d;
  logic          out_valid_q;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic [47:0]   mem_q [DEPTH];

  logic [47:0]   rd_frame;
  logic [23:0]   hold_l_next, hold_r_next;
  logic          push, pop, ovf_set, unf_set;

  assign rd_frame = mem_q[rd_ptr_q];

  // Value the hold register takes after it has been presented once.
`ifdef AUDIO_SAMPLE_BUFFER_DECAY_EN
  assign hold_l_next = 24'($signed(hold_l_q) >>> 1);
  assign hold_r_next = 24'($signed(hold_r_q) >>> 1);
`else
  assign hold_l_next = hold_l_q;
  assign hold_r_next = hold_r_q;
`endif

  always_comb begin
    state_d  = state_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    out_l_d  = out_l_q;
    out_r_d  = out_r_q;
    pop      = 1'b0;
    unf_set  = 1'b0;

    case (state_q)
      FILL: begin
        if (out_req) begin
          out_l_d = '0;
          out_r_d = '0;
        end
      end
      RUN: begin
        if (out_req) begin
          // Emptiness is judged on the registered level: a push arriving in
          // the same cycle is not yet visible to the reader.
          if (level_q != '0) begin
            pop      = 1'b1;
            out_l_d  = rd_frame[47:24];
            out_r_d  = rd_frame[23:0];
            hold_l_d = rd_frame[47:24];
            hold_r_d = rd_frame[23:0];
          end else begin
            state_d  = UNDERRUN;
            out_l_d  = hold_l_q;
            out_r_d  = hold_r_q;
            hold_l_d = hold_l_next;
            hold_r_d = hold_r_next;
            unf_set  = 1'b1;
          end
        end
      end
      UNDERRUN: begin
        if (out_req) begin
          out_l_d  = hold_l_q;
          out_r_d  = hold_r_q;
          hold_l_d = hold_l_next;
          hold_r_d = hold_r_next;
        end
      end
      default: state_d = FILL;
    endcase

    // A full FIFO still accepts a push when a pop frees a slot this cycle.
    push    = in_valid && ((level_q != C_DEPTH) || pop);
    ovf_set = in_valid && !push;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    // Leaving FILL/UNDERRUN uses the post-update level so RUN is reached on
    // the same edge that stores the FILL_LEVEL-th frame.
    if (((state_q == FILL) || (state_q == UNDERRUN)) && (level_d >= C_FILL)) begin
      state_d = RUN;
    end

    // Setting events win over clear_flags.
    ovf_d = ovf_set ? 1'b1 : (clear_flags ? 1'b0 : ovf_q);
    unf_d = unf_set ? 1'b1 : (clear_flags ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_req;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Frame storage needs no reset: the pointers and level define its content.
  always_ff @(posedge clk_sys) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= {in_left, in_right};
    end
  end

  assign out_left        = out_l_q;
  assign out_right       = out_r_q;
  assign out_valid       = out_valid_q;
  assign level           = level_q;
  assign state           = state_q;
  assign overflow_sticky = ovf_q;
  assign underrun_sticky = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_sample_buffer
// Purpose  : Self-checking bench for audio_sample_buffer. A queue-based model
//            of the buffer's behaviour supplies every expected value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_sample_buffer;

  localparam int DEPTH = 16;
  localparam int FILL  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] in_left = '0, in_right = '0;
  logic        in_valid = 1'b0, out_req = 1'b0, clear_flags = 1'b0;
  logic [23:0] out_left, out_right;
  logic        out_valid;
  logic [4:0]  level;
  logic [1:0]  state;
  logic        overflow_sticky, underrun_sticky;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  logic [47:0] q[$];
  int          m_state;
  logic [23:0] m_hl, m_hr, m_ol, m_or;
  bit          m_ov, m_ovf, m_unf;

  audio_sample_buffer #(.DEPTH(DEPTH), .FILL_LEVEL(FILL)) dut (
    .clk_sys(clk), .rst(rst),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
    .out_req(out_req), .clear_flags(clear_flags),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .level(level), .state(state),
    .overflow_sticky(overflow_sticky), .underrun_sticky(underrun_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] halve(input logic [23:0] x);
    return {x[23], x[23:1]};
  endfunction

  function automatic logic [57:0] model_vec();
    return {m_ov, 5'(q.size()), 2'(m_state), m_ovf, m_unf, m_ol, m_or};
  endfunction

  function automatic logic [57:0] dut_vec();
    return {out_valid, level, state, overflow_sticky, underrun_sticky, out_left, out_right};
  endfunction

  task automatic model_reset();
    q.delete();
    m_state = 0; m_hl = '0; m_hr = '0; m_ol = '0; m_or = '0;
    m_ov = 0; m_ovf = 0; m_unf = 0;
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic drive(input bit v, input logic [23:0] l, input logic [23:0] r,
                       input bit req, input bit clr);
    logic [47:0] f;
    int s0;
    bit ovs, uns;
    in_valid = v; in_left = l; in_right = r; out_req = req; clear_flags = clr;
    s0 = m_state; ovs = 0; uns = 0;
    m_ov = req;
    if (req) begin
      if (s0 == 0) begin
        m_ol = '0; m_or = '0;
      end else if (s0 == 1 && q.size() > 0) begin
        f = q.pop_front();
        m_ol = f[47:24]; m_or = f[23:0];
        m_hl = m_ol; m_hr = m_or;
      end else begin
        if (s0 == 1) begin m_state = 2; uns = 1; end
        m_ol = m_hl; m_or = m_hr;
`ifdef AUDIO_SAMPLE_BUFFER_DECAY_EN
        m_hl = halve(m_hl); m_hr = halve(m_hr);
`endif
      end
    end
    if (v) begin
      if (q.size() < DEPTH) q.push_back({l, r});
      else ovs = 1;
    end
    if (s0 != 1 && q.size() >= FILL) m_state = 1;
    if (ovs) m_ovf = 1; else if (clr) m_ovf = 0;
    if (uns) m_unf = 1; else if (clr) m_unf = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input bit busy);
    rst = 1'b1;
    in_valid = busy; out_req = busy; clear_flags = 1'b0;
    in_left = 24'($urandom); in_right = 24'($urandom);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    checks++;
    if ({out_valid, level, state, overflow_sticky, underrun_sticky} !== 10'b0) begin
      errors++;
      $display("FAIL reset_status: got v=%b lvl=%0d st=%0d ovf=%b unf=%b required all zero",
               out_valid, level, state, overflow_sticky, underrun_sticky);
    end
    checks++;
    if ({out_left, out_right} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h required 0/0", out_left, out_right);
    end
  endtask

  task automatic test_fill_run();
    do_reset(0);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 24'(i * 256), 24'($urandom), i == 1, 0);
      if (i == 1) begin
        checks++;
        if ({out_valid, out_left, out_right} !== {1'b1, 48'h0}) begin
          errors++;
          $display("FAIL fill_answer: got v=%b %h/%h required v=1 0/0", out_valid, out_left, out_right);
        end
      end
      checks++;
      if (state !== ((i < 8) ? 2'd0 : 2'd1) || level !== 5'(i)) begin
        errors++;
        $display("FAIL fill_progress: push %0d got st=%0d lvl=%0d required st=%0d lvl=%0d",
                 i, state, level, (i < 8) ? 0 : 1, i);
      end
    end
    drive(0, '0, '0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_left !== 24'h000100 || level !== 5'd7) begin
      errors++;
      $display("FAIL first_run_pop: got v=%b L=%h lvl=%0d required v=1 L=000100 lvl=7",
               out_valid, out_left, level);
    end
    drive(0, '0, '0, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || out_left !== 24'h000100) begin
      errors++;
      $display("FAIL output_hold: got v=%b L=%h required v=0 L=000100", out_valid, out_left);
    end
  endtask

  task automatic test_overflow();
    logic [23:0] f17;
    f17 = 24'hABCDEF;
    do_reset(0);
    for (int i = 1; i <= 17; i++) drive(1, (i == 17) ? f17 : 24'(i * 256), 24'(i), 0, 0);
    checks++;
    if (level !== 5'd16 || overflow_sticky !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got lvl=%0d ovf=%b required lvl=16 ovf=1", level, overflow_sticky);
    end
    for (int i = 1; i <= 17; i++) begin
      drive(0, '0, '0, 1, 0);
      checks++;
      if (dut_vec() !== model_vec() || out_left === f17) begin
        errors++;
        $display("FAIL overflow_drain %0d: got %h required %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_full_simul();
    do_reset(0);
    for (int i = 1; i <= 16; i++) drive(1, 24'($urandom), 24'($urandom), 0, 0);
    drive(1, 24'h123456, 24'h654321, 1, 0);
    checks++;
    if (level !== 5'd16 || overflow_sticky !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL full_push_pop: got %h required %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_clear_priority();
    // FIFO is still full from the previous scenario.
    drive(1, 24'h0F0F0F, 24'h0F0F0F, 0, 1);
    checks++;
    if (overflow_sticky !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_set: got ovf=%b required 1", overflow_sticky);
    end
    drive(0, '0, '0, 0, 1);
    checks++;
    if (overflow_sticky !== 1'b0 || level !== 5'd16) begin
      errors++;
      $display("FAIL clear_alone: got ovf=%b lvl=%0d required ovf=0 lvl=16", overflow_sticky, level);
    end
  endtask

  task automatic test_underrun();
    logic [23:0] exp_l [3];
    logic [23:0] exp_r [3];
`ifdef AUDIO_SAMPLE_BUFFER_DECAY_EN
    exp_l = '{24'h400000, 24'h200000, 24'h100000};
    exp_r = '{24'h800000, 24'hC00000, 24'hE00000};
`else
    exp_l = '{24'h400000, 24'h400000, 24'h400000};
    exp_r = '{24'h800000, 24'h800000, 24'h800000};
`endif
    do_reset(0);
    for (int i = 1; i <= 7; i++) drive(1, 24'($urandom), 24'($urandom), 0, 0);
    drive(1, 24'h400000, 24'h800000, 0, 0);
    for (int i = 1; i <= 8; i++) drive(0, '0, '0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, '0, '0, 1, 0);
      checks++;
      if (out_valid !== 1'b1 || out_left !== exp_l[k] || out_right !== exp_r[k] ||
          state !== 2'd2 || underrun_sticky !== 1'b1) begin
        errors++;
        $display("FAIL underrun_%0d: got v=%b %h/%h st=%0d unf=%b required v=1 %h/%h st=2 unf=1",
                 k, out_valid, out_left, out_right, state, underrun_sticky, exp_l[k], exp_r[k]);
      end
    end
    for (int i = 1; i <= 8; i++) drive(1, 24'($urandom), 24'($urandom), 0, 0);
    checks++;
    if (state !== 2'd1 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL underrun_recover: got %h required %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_async_reset();
    do_reset(0);
    for (int i = 1; i <= 8; i++) drive(1, 24'($urandom), 24'($urandom), 0, 0);
    for (int i = 1; i <= 3; i++) drive(0, '0, '0, 1, 0);
    checks++;
    if (level !== 5'd5 || out_valid !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("FAIL pre_reset: got lvl=%0d v=%b st=%0d required lvl=5 v=1 st=1", level, out_valid, state);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (level !== 5'd0 || state !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got lvl=%0d st=%0d v=%b required 0/0/0", level, state, out_valid);
    end
    do_reset(0);
  endtask

  task automatic test_random();
    int pv [4] = '{75, 30, 50, 60};
    int pr [4] = '{30, 70, 50, 55};
    do_reset(0);
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 150; c++) begin
        drive($urandom_range(0, 99) < pv[ph], 24'($urandom), 24'($urandom),
              $urandom_range(0, 99) < pr[ph], $urandom_range(0, 99) < 5);
        checks++;
        if (dut_vec() !== model_vec()) begin
          errors++;
          $display("FAIL random ph%0d c%0d: got %h required %h", ph, c, dut_vec(), model_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_run();
    test_overflow();
    test_full_simul();
    test_clear_priority();
    test_underrun();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
